// File: rtl/serial_subtractor_nbit_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
// Holds the FSM state encoding and the bit-counter width helper.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A one-bit operand still needs a one-bit counter.
  function automatic int cntWidth(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_subtractor_nbit_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The producer/consumer side uses master; the subtractor uses slave.
interface serial_subtractor_nbit_if #(
  parameter int N = 4
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] diff;
  logic         bout;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout
  );

endinterface

// File: rtl/serial_subtractor_nbit_full_sub.sv
// Combinational 1-bit full subtractor: d = a - b - bin, with the borrow out.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial N-bit unsigned subtractor: one full-subtractor cell, LSB first,
// with valid/ready handshakes on the operand and result sides.
module serial_subtractor_nbit
  import serial_arith_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_subtractor_nbit_if.slave  bus
);

  localparam int             CW   = cntWidth(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  state_t        r_state;
  state_t        w_stateNext;
  logic [N-1:0]  r_aShift;
  logic [N-1:0]  r_bShift;
  logic [N-1:0]  r_diffShift;
  logic [CW-1:0] r_count;
  logic          r_borrow;
  logic          r_bout;
  logic          w_accept;
  logic          w_lastBit;
  logic          w_d;
  logic          w_bo;

  assign w_accept  = bus.in_valid && (r_state == IDLE);
  assign w_lastBit = (r_state == RUN) && (r_count == LAST);

  full_sub u_cell (
    .a    (r_aShift[0]),
    .b    (r_bShift[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_stateNext = RUN;
        end
      end
      RUN: begin
        if (r_count == LAST) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Each RUN cycle retires one bit; the new difference bit enters at the MSB
  // so after N shifts the result sits right-aligned in r_diffShift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aShift    <= '0;
      r_bShift    <= '0;
      r_diffShift <= '0;
      r_count     <= '0;
      r_borrow    <= 1'b0;
      r_bout      <= 1'b0;
    end else if (w_accept) begin
      r_aShift <= bus.a;
      r_bShift <= bus.b;
      r_borrow <= bus.bin;
      r_count  <= '0;
    end else if (r_state == RUN) begin
      r_aShift    <= r_aShift >> 1;
      r_bShift    <= r_bShift >> 1;
      r_diffShift <= (r_diffShift >> 1) | (N'(w_d) << (N - 1));
      r_borrow    <= w_bo;
      r_count     <= r_count + CW'(1);
      if (w_lastBit) begin
        r_bout <= w_bo;
      end
    end
  end

  assign bus.diff = r_diffShift;
  assign bus.bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Directed and randomized checks of the bit-serial subtractor at N = 4, 8 and 1.
module tb_serial_subtractor_nbit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passes = 0;

  serial_subtractor_nbit_if #(.N(4)) if4 ();
  serial_subtractor_nbit_if #(.N(8)) if8 ();
  serial_subtractor_nbit_if #(.N(1)) if1 ();

  serial_subtractor_nbit #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  serial_subtractor_nbit #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  serial_subtractor_nbit #(.N(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  // Present one operand set to the N=4 instance and return just after the accept edge.
  task automatic applyStimulus4(input logic [3:0] a, input logic [3:0] b, input logic bin);
    if4.in_valid = 1'b1;
    if4.a        = a;
    if4.b        = b;
    if4.bin      = bin;
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    if4.a        = ~a;
    if4.b        = ~b;
    if4.bin      = ~bin;
  endtask

  task automatic waitOut4(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!if4.out_valid && cyc < 20);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++; if (if4.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready4: got %b expected 1", if4.in_ready); else passes++;
    checks++; if (if4.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid4: got %b expected 0", if4.out_valid); else passes++;
    checks++; if (if4.diff !== 4'd0) $display("[TB] FAIL reset_diff4: got %0d expected 0", if4.diff); else passes++;
    checks++; if (if4.bout !== 1'b0) $display("[TB] FAIL reset_bout4: got %b expected 0", if4.bout); else passes++;
    checks++; if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0 || if8.diff !== 8'd0) $display("[TB] FAIL reset_n8: got rdy=%b vld=%b diff=%0d expected 1 0 0", if8.in_ready, if8.out_valid, if8.diff); else passes++;
    checks++; if (if1.in_ready !== 1'b1 || if1.out_valid !== 1'b0 || if1.diff !== 1'b0) $display("[TB] FAIL reset_n1: got rdy=%b vld=%b diff=%0d expected 1 0 0", if1.in_ready, if1.out_valid, if1.diff); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc;
    if4.out_ready = 1'b1;
    applyStimulus4(4'd9, 4'd3, 1'b0);
    checks++; if (if4.in_ready !== 1'b0) $display("[TB] FAIL basic_busy: got in_ready=%b expected 0", if4.in_ready); else passes++;
    waitOut4(cyc);
    checks++; if (cyc !== 4) $display("[TB] FAIL basic_latency: got %0d expected 4", cyc); else passes++;
    checks++; if (if4.diff !== 4'd6) $display("[TB] FAIL basic_diff: got %0d expected 6", if4.diff); else passes++;
    checks++; if (if4.bout !== 1'b0) $display("[TB] FAIL basic_bout: got %b expected 0", if4.bout); else passes++;
    checks++; if (if4.in_ready !== 1'b0) $display("[TB] FAIL basic_exclusive: got in_ready=%b expected 0", if4.in_ready); else passes++;
    @(posedge clk); #1;
    checks++; if (if4.in_ready !== 1'b1 || if4.out_valid !== 1'b0) $display("[TB] FAIL basic_return_idle: got rdy=%b vld=%b expected 1 0", if4.in_ready, if4.out_valid); else passes++;
  endtask

  task automatic test_borrow();
    int cyc;
    applyStimulus4(4'd3, 4'd9, 1'b0);
    waitOut4(cyc);
    checks++; if (if4.diff !== 4'd10) $display("[TB] FAIL borrow_diff_3m9: got %0d expected 10", if4.diff); else passes++;
    checks++; if (if4.bout !== 1'b1) $display("[TB] FAIL borrow_bout_3m9: got %b expected 1", if4.bout); else passes++;
    @(posedge clk); #1;
    applyStimulus4(4'd0, 4'd0, 1'b1);
    waitOut4(cyc);
    checks++; if (if4.diff !== 4'd15) $display("[TB] FAIL borrow_diff_bin: got %0d expected 15", if4.diff); else passes++;
    checks++; if (if4.bout !== 1'b1) $display("[TB] FAIL borrow_bout_bin: got %b expected 1", if4.bout); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_boundary();
    int cyc;
    applyStimulus4(4'd5, 4'd5, 1'b0);
    waitOut4(cyc);
    checks++; if (if4.diff !== 4'd0 || if4.bout !== 1'b0) $display("[TB] FAIL boundary_equal: got diff=%0d bout=%b expected 0 0", if4.diff, if4.bout); else passes++;
    @(posedge clk); #1;
    applyStimulus4(4'd15, 4'd0, 1'b1);
    waitOut4(cyc);
    checks++; if (if4.diff !== 4'd14 || if4.bout !== 1'b0) $display("[TB] FAIL boundary_max: got diff=%0d bout=%b expected 14 0", if4.diff, if4.bout); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int cyc;
    if4.out_ready = 1'b0;
    applyStimulus4(4'd12, 4'd5, 1'b1);
    waitOut4(cyc);
    checks++; if (cyc !== 4 || if4.diff !== 4'd6) $display("[TB] FAIL bp_first: got lat=%0d diff=%0d expected 4 6", cyc, if4.diff); else passes++;
    if4.in_valid = 1'b1;
    if4.a        = 4'd2;
    if4.b        = 4'd1;
    if4.bin      = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++; if (if4.diff !== 4'd6 || if4.bout !== 1'b0) $display("[TB] FAIL bp_hold_result: got diff=%0d bout=%b expected 6 0", if4.diff, if4.bout); else passes++;
      checks++; if (if4.out_valid !== 1'b1 || if4.in_ready !== 1'b0) $display("[TB] FAIL bp_hold_flags: got vld=%b rdy=%b expected 1 0", if4.out_valid, if4.in_ready); else passes++;
    end
    if4.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (if4.out_valid !== 1'b0 || if4.in_ready !== 1'b1) $display("[TB] FAIL bp_release: got vld=%b rdy=%b expected 0 1", if4.out_valid, if4.in_ready); else passes++;
    @(posedge clk); #1;
    checks++; if (if4.in_ready !== 1'b0) $display("[TB] FAIL bp_new_accept: got in_ready=%b expected 0", if4.in_ready); else passes++;
    if4.in_valid = 1'b0;
    waitOut4(cyc);
    checks++; if (cyc !== 4 || if4.diff !== 4'd1 || if4.bout !== 1'b0) $display("[TB] FAIL bp_second: got lat=%0d diff=%0d bout=%b expected 4 1 0", cyc, if4.diff, if4.bout); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    logic seen;
    applyStimulus4(4'd13, 4'd2, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (if4.out_valid !== 1'b0 || if4.in_ready !== 1'b1) $display("[TB] FAIL midrst_flags: got vld=%b rdy=%b expected 0 1", if4.out_valid, if4.in_ready); else passes++;
    checks++; if (if4.diff !== 4'd0 || if4.bout !== 1'b0) $display("[TB] FAIL midrst_result: got diff=%0d bout=%b expected 0 0", if4.diff, if4.bout); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (if4.out_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) $display("[TB] FAIL midrst_no_pulse: got out_valid pulse=%b expected 0", seen); else passes++;
    applyStimulus4(4'd7, 4'd2, 1'b0);
    waitOut4(cyc);
    checks++; if (cyc !== 4 || if4.diff !== 4'd5 || if4.bout !== 1'b0) $display("[TB] FAIL midrst_next_op: got lat=%0d diff=%0d bout=%b expected 4 5 0", cyc, if4.diff, if4.bout); else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_random8();
    logic [7:0] a, b, expD;
    logic       bin, expB;
    int         cyc, stall;
    for (int i = 0; i < 1000; i++) begin
      a    = 8'($urandom);
      b    = 8'($urandom);
      bin  = 1'($urandom);
      expD = a - b - {7'd0, bin};
      expB = ({1'b0, a} < ({1'b0, b} + {8'd0, bin}));
      checks++; if (if8.in_ready !== 1'b1) $display("[TB] FAIL rand8_ready: got %b expected 1", if8.in_ready); else passes++;
      if8.in_valid = 1'b1; if8.a = a; if8.b = b; if8.bin = bin;
      @(posedge clk); #1;
      if8.in_valid = 1'b0; if8.a = ~a; if8.b = ~b; if8.bin = ~bin;
      cyc = 0;
      do begin @(posedge clk); #1; cyc++; end while (!if8.out_valid && cyc < 40);
      checks++; if (cyc !== 8) $display("[TB] FAIL rand8_latency: got %0d expected 8", cyc); else passes++;
      checks++; if (if8.diff !== expD || if8.bout !== expB) $display("[TB] FAIL rand8_result: a=%0d b=%0d bin=%b got diff=%0d bout=%b expected %0d %b", a, b, bin, if8.diff, if8.bout, expD, expB); else passes++;
      stall = 0;
      while (if8.out_valid && stall < 50) begin
        if8.out_ready = 1'($urandom);
        @(posedge clk); #1;
        stall++;
      end
      if8.out_ready = 1'b0;
      checks++;
      if (if8.out_valid !== 1'b0) begin
        $display("[TB] FAIL rand8_drain: got out_valid=%b expected 0", if8.out_valid);
        break;
      end else passes++;
    end
  endtask

  task automatic test_random1();
    logic a, b, bin, expD, expB;
    int   cyc, stall;
    for (int i = 0; i < 1000; i++) begin
      a    = 1'($urandom);
      b    = 1'($urandom);
      bin  = 1'($urandom);
      expD = a - b - bin;
      expB = ({1'b0, a} < ({1'b0, b} + {1'b0, bin}));
      checks++; if (if1.in_ready !== 1'b1) $display("[TB] FAIL rand1_ready: got %b expected 1", if1.in_ready); else passes++;
      if1.in_valid = 1'b1; if1.a = a; if1.b = b; if1.bin = bin;
      @(posedge clk); #1;
      if1.in_valid = 1'b0; if1.a = ~a; if1.b = ~b; if1.bin = ~bin;
      cyc = 0;
      do begin @(posedge clk); #1; cyc++; end while (!if1.out_valid && cyc < 20);
      checks++; if (cyc !== 1) $display("[TB] FAIL rand1_latency: got %0d expected 1", cyc); else passes++;
      checks++; if (if1.diff !== expD || if1.bout !== expB) $display("[TB] FAIL rand1_result: a=%b b=%b bin=%b got diff=%b bout=%b expected %b %b", a, b, bin, if1.diff, if1.bout, expD, expB); else passes++;
      stall = 0;
      while (if1.out_valid && stall < 50) begin
        if1.out_ready = 1'($urandom);
        @(posedge clk); #1;
        stall++;
      end
      if1.out_ready = 1'b0;
      checks++;
      if (if1.out_valid !== 1'b0) begin
        $display("[TB] FAIL rand1_drain: got out_valid=%b expected 0", if1.out_valid);
        break;
      end else passes++;
    end
  endtask

  initial begin
    if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.bin = 1'b0; if4.out_ready = 1'b0;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0; if8.out_ready = 1'b0;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.bin = 1'b0; if1.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_borrow();
    test_boundary();
    test_backpressure();
    test_reset_mid_run();
    test_random8();
    test_random1();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
